// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 scan-code sequencer: decodes make/break/E0/E1 sequences into
// per-player held-key bitmaps, attack edge pulses and one-cycle key events.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for the first byte of a sequence
// S_BRK     | F0 seen, next byte completes a break code
// S_EXT     | E0 seen, next byte completes an extended make (or F0)
// S_EXT_BRK | E0 F0 seen, next byte completes an extended break
// S_PAUSE   | E1 seen, swallowing the rest of the Pause sequence
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       flush,
    output logic [4:0] p1_keys,
    output logic [4:0] p2_keys,
    output logic       p1_attack_pulse,
    output logic       p2_attack_pulse,
    output logic       key_event,
    output logic [7:0] event_code,
    output logic       event_release,
    output logic       event_extended,
    output logic       seq_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_PAUSE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [CW-1:0] tmo_q;
    logic [4:0]    p1_keys_q, p1_keys_d;
    logic [4:0]    p2_keys_q, p2_keys_d;
    logic          p1_pulse_q, p2_pulse_q;
    logic          key_event_q, seq_timeout_q;
    logic [7:0]    event_code_q;
    logic          event_release_q, event_extended_q;
    logic          is_prefix, done, rel, ext;

    assign is_prefix = (received_data == 8'hE0) || (received_data == 8'hF0) ||
                       (received_data == 8'hE1);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        done    = 1'b0;
        rel     = 1'b0;
        ext     = 1'b0;
        if (received_data_en) begin
            if (state_q == S_PAUSE) begin
                skip_d = skip_q - 3'd1;
                if (skip_q == 3'd1) state_d = S_IDLE;
            end else if (state_q == S_EXT && received_data == 8'hF0) begin
                state_d = S_EXT_BRK;
            end else if (state_q == S_IDLE || is_prefix) begin
                // A stray prefix drops the pending sequence and restarts from idle.
                state_d = S_IDLE;
                case (received_data)
                    8'hE0: state_d = S_EXT;
                    8'hF0: state_d = S_BRK;
                    8'hE1: begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end
                    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                    default: done = 1'b1;
                endcase
            end else begin
                done    = 1'b1;
                rel     = (state_q == S_BRK) || (state_q == S_EXT_BRK);
                ext     = (state_q == S_EXT) || (state_q == S_EXT_BRK);
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        p1_keys_d = p1_keys_q;
        p2_keys_d = p2_keys_q;
        if (done) begin
            if (!ext) begin
                case (received_data)
                    8'h1D:   p1_keys_d[0] = !rel;
                    8'h1C:   p1_keys_d[1] = !rel;
                    8'h1B:   p1_keys_d[2] = !rel;
                    8'h23:   p1_keys_d[3] = !rel;
                    8'h29:   p1_keys_d[4] = !rel;
                    default: ;
                endcase
            end else begin
                case (received_data)
                    8'h75:   p2_keys_d[0] = !rel;
                    8'h6B:   p2_keys_d[1] = !rel;
                    8'h72:   p2_keys_d[2] = !rel;
                    8'h74:   p2_keys_d[3] = !rel;
                    default: ;
                endcase
            end
            if (received_data == 8'h5A) p2_keys_d[4] = !rel;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            skip_q           <= 3'd0;
            tmo_q            <= '0;
            p1_keys_q        <= 5'd0;
            p2_keys_q        <= 5'd0;
            p1_pulse_q       <= 1'b0;
            p2_pulse_q       <= 1'b0;
            key_event_q      <= 1'b0;
            seq_timeout_q    <= 1'b0;
            event_code_q     <= 8'd0;
            event_release_q  <= 1'b0;
            event_extended_q <= 1'b0;
        end else if (flush) begin
            state_q       <= S_IDLE;
            skip_q        <= 3'd0;
            tmo_q         <= '0;
            p1_keys_q     <= 5'd0;
            p2_keys_q     <= 5'd0;
            p1_pulse_q    <= 1'b0;
            p2_pulse_q    <= 1'b0;
            key_event_q   <= 1'b0;
            seq_timeout_q <= 1'b0;
        end else begin
            seq_timeout_q <= 1'b0;
            key_event_q   <= done;
            p1_keys_q     <= p1_keys_d;
            p2_keys_q     <= p2_keys_d;
            p1_pulse_q    <= p1_keys_d[4] & ~p1_keys_q[4];
            p2_pulse_q    <= p2_keys_d[4] & ~p2_keys_q[4];
            if (received_data_en) begin
                state_q <= state_d;
                skip_q  <= skip_d;
                tmo_q   <= '0;
            end else if (state_q != S_IDLE) begin
                if (tmo_q == TMO_LAST) begin
                    state_q       <= S_IDLE;
                    skip_q        <= 3'd0;
                    tmo_q         <= '0;
                    seq_timeout_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
            if (done) begin
                event_code_q     <= received_data;
                event_release_q  <= rel;
                event_extended_q <= ext;
            end
        end
    end

    assign p1_keys         = p1_keys_q;
    assign p2_keys         = p2_keys_q;
    assign p1_attack_pulse = p1_pulse_q;
    assign p2_attack_pulse = p2_pulse_q;
    assign key_event       = key_event_q;
    assign event_code      = event_code_q;
    assign event_release   = event_release_q;
    assign event_extended  = event_extended_q;
    assign seq_timeout     = seq_timeout_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: byte-stream vector table plus
// hand-written timeout, flush and reset sequences.
module tb_ps2_key_tracker;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       flush;
    logic [4:0] p1_keys, p2_keys;
    logic       p1_attack_pulse, p2_attack_pulse;
    logic       key_event;
    logic [7:0] event_code;
    logic       event_release, event_extended, seq_timeout;

    int checks = 0;
    int errors = 0;

    ps2_key_tracker #(.TIMEOUT_CYCLES(16)) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .flush            (flush),
        .p1_keys          (p1_keys),
        .p2_keys          (p2_keys),
        .p1_attack_pulse  (p1_attack_pulse),
        .p2_attack_pulse  (p2_attack_pulse),
        .key_event        (key_event),
        .event_code       (event_code),
        .event_release    (event_release),
        .event_extended   (event_extended),
        .seq_timeout      (seq_timeout)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [7:0] data;
        logic       ev;
        logic [7:0] code;
        logic       rel;
        logic       ext;
        logic [4:0] p1;
        logic [4:0] p2;
        logic       pa1;
        logic       pa2;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte is sampled at the posedge inside; returns at the next negedge with outputs settled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK_50);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
    endtask

    task automatic add(input logic [7:0] d, input logic ev, input logic [7:0] code,
                       input logic rel, input logic ext, input logic [4:0] p1,
                       input logic [4:0] p2, input logic pa1, input logic pa2);
        vec_t v;
        v.data = d; v.ev = ev; v.code = code; v.rel = rel; v.ext = ext;
        v.p1 = p1; v.p2 = p2; v.pa1 = pa1; v.pa2 = pa2;
        vq.push_back(v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " p1_keys"}, {3'b0, p1_keys}, 8'h00);
        chk({tag, " p2_keys"}, {3'b0, p2_keys}, 8'h00);
        chk({tag, " key_event"}, {7'b0, key_event}, 8'h00);
        chk({tag, " event_code"}, event_code, 8'h00);
        chk({tag, " rel/ext"}, {6'b0, event_release, event_extended}, 8'h00);
        chk({tag, " pulses"}, {6'b0, p1_attack_pulse, p2_attack_pulse}, 8'h00);
        chk({tag, " seq_timeout"}, {7'b0, seq_timeout}, 8'h00);
    endtask

    task automatic chk_event(input string tag, input logic [7:0] code, input logic rel,
                             input logic ext);
        chk({tag, " key_event"}, {7'b0, key_event}, 8'h01);
        chk({tag, " event_code"}, event_code, code);
        chk({tag, " rel/ext"}, {6'b0, event_release, event_extended}, {6'b0, rel, ext});
    endtask

    initial begin
        int pulses, pulse_at, evs;

        // make/break, typematic attack, extended P2, pause, ignored, unmapped
        add(8'h1D, 1, 8'h1D, 0, 0, 5'b00001, 5'b00000, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 5'b00001, 5'b00000, 0, 0);
        add(8'h1D, 1, 8'h1D, 1, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'h29, 1, 8'h29, 0, 0, 5'b10000, 5'b00000, 1, 0);
        add(8'h29, 1, 8'h29, 0, 0, 5'b10000, 5'b00000, 0, 0);
        add(8'h29, 1, 8'h29, 0, 0, 5'b10000, 5'b00000, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 5'b10000, 5'b00000, 0, 0);
        add(8'h29, 1, 8'h29, 1, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'h75, 1, 8'h75, 0, 1, 5'b00000, 5'b00001, 0, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 5'b00000, 5'b00001, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 5'b00000, 5'b00001, 0, 0);
        add(8'h75, 1, 8'h75, 1, 1, 5'b00000, 5'b00000, 0, 0);
        add(8'hE1, 0, 8'h00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'h14, 0, 8'h00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'h77, 0, 8'h00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'hE1, 0, 8'h00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'h14, 0, 8'h00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'h77, 0, 8'h00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(8'h23, 1, 8'h23, 0, 0, 5'b01000, 5'b00000, 0, 0);
        add(8'hAA, 0, 8'h00, 0, 0, 5'b01000, 5'b00000, 0, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 5'b01000, 5'b00000, 0, 0);
        add(8'h5A, 1, 8'h5A, 0, 1, 5'b01000, 5'b10000, 0, 1);
        add(8'h5A, 1, 8'h5A, 0, 0, 5'b01000, 5'b10000, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 5'b01000, 5'b10000, 0, 0);
        add(8'h5A, 1, 8'h5A, 1, 0, 5'b01000, 5'b00000, 0, 0);
        add(8'h12, 1, 8'h12, 0, 0, 5'b01000, 5'b00000, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 5'b01000, 5'b00000, 0, 0);
        add(8'h23, 1, 8'h23, 1, 0, 5'b00000, 5'b00000, 0, 0);

        reset = 1'b1; flush = 1'b0; received_data = 8'h00; received_data_en = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk_all_zero("reset");
        reset = 1'b0;

        foreach (vq[i]) begin
            send_byte(vq[i].data);
            chk($sformatf("vec%0d key_event", i), {7'b0, key_event}, {7'b0, vq[i].ev});
            if (vq[i].ev) begin
                chk($sformatf("vec%0d event_code", i), event_code, vq[i].code);
                chk($sformatf("vec%0d rel/ext", i), {6'b0, event_release, event_extended},
                    {6'b0, vq[i].rel, vq[i].ext});
            end
            chk($sformatf("vec%0d p1_keys", i), {3'b0, p1_keys}, {3'b0, vq[i].p1});
            chk($sformatf("vec%0d p2_keys", i), {3'b0, p2_keys}, {3'b0, vq[i].p2});
            chk($sformatf("vec%0d pulses", i), {6'b0, p1_attack_pulse, p2_attack_pulse},
                {6'b0, vq[i].pa1, vq[i].pa2});
            chk($sformatf("vec%0d seq_timeout", i), {7'b0, seq_timeout}, 8'h00);
        end

        // key_event is one cycle wide
        @(negedge CLOCK_50);
        chk("event width", {7'b0, key_event}, 8'h00);
        chk("event hold", event_code, 8'h23);

        // timeout after F0: fires exactly once, 16 cycles after the byte
        send_byte(8'hF0);
        pulses = 0; pulse_at = 0; evs = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge CLOCK_50);
            if (seq_timeout) begin pulses++; pulse_at = i; end
            if (key_event) evs++;
        end
        chk("tmo pulses", 8'(pulses), 8'd1);
        chk("tmo cycle", 8'(pulse_at), 8'd16);
        chk("tmo no event", 8'(evs), 8'd0);
        send_byte(8'h1C);
        chk_event("after tmo", 8'h1C, 0, 0);
        chk("after tmo p1", {3'b0, p1_keys}, 8'h02);

        // strobe in the expiry cycle: byte wins, no timeout
        send_byte(8'hF0);
        pulses = 0;
        repeat (14) begin
            @(negedge CLOCK_50);
            if (seq_timeout) pulses++;
        end
        send_byte(8'h1C);
        chk_event("expiry strobe", 8'h1C, 1, 0);
        chk("expiry strobe p1", {3'b0, p1_keys}, 8'h00);
        repeat (20) begin
            @(negedge CLOCK_50);
            if (seq_timeout) pulses++;
        end
        chk("expiry no tmo", 8'(pulses), 8'd0);

        // timeout also abandons a pause sequence
        send_byte(8'hE1);
        pulses = 0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (seq_timeout) pulses++;
        end
        chk("pause tmo", 8'(pulses), 8'd1);
        send_byte(8'h1B);
        chk_event("after pause tmo", 8'h1B, 0, 0);
        chk("after pause tmo p1", {3'b0, p1_keys}, 8'h04);

        // discarded F0 then extended make
        send_byte(8'hF0);
        chk("discard F0 ev", {7'b0, key_event}, 8'h00);
        send_byte(8'hE0);
        chk("discard E0 ev", {7'b0, key_event}, 8'h00);
        send_byte(8'h74);
        chk_event("ext 74", 8'h74, 0, 1);
        chk("ext 74 p2", {3'b0, p2_keys}, 8'h08);

        // flush beats a same-cycle byte and clears both bitmaps
        @(negedge CLOCK_50);
        flush = 1'b1; received_data = 8'h1D; received_data_en = 1'b1;
        @(negedge CLOCK_50);
        flush = 1'b0; received_data_en = 1'b0;
        chk("flush p1", {3'b0, p1_keys}, 8'h00);
        chk("flush p2", {3'b0, p2_keys}, 8'h00);
        chk("flush ev", {7'b0, key_event}, 8'h00);

        // flush mid-sequence drops the E0 prefix
        send_byte(8'hE0);
        @(negedge CLOCK_50);
        flush = 1'b1;
        @(negedge CLOCK_50);
        flush = 1'b0;
        send_byte(8'h75);
        chk_event("post flush", 8'h75, 0, 0);
        chk("post flush p2", {3'b0, p2_keys}, 8'h00);

        // reset mid-E0
        send_byte(8'h1D);
        send_byte(8'hE0);
        #2 reset = 1'b1;
        #1 chk_all_zero("mid reset");
        @(negedge CLOCK_50);
        reset = 1'b0;
        send_byte(8'h6B);
        chk_event("post reset", 8'h6B, 0, 0);
        chk("post reset p2", {3'b0, p2_keys}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Scan-code sequencer between `PS2_Controller` and the game logic. Consumes the received byte stream and decodes PS/2 Set-2 make, break, extended (E0) and Pause (E1) sequences. Maintains a held-key bitmap for each player's five controls and emits a one-cycle event per completed scan code. Attack presses produce edge pulses, with typematic repeats suppressed.

## Interface
- `TIMEOUT_CYCLES`, default 2_500_000 (50 ms at 50 MHz): cycles a partial sequence may wait for its next byte before it is abandoned.
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `received_data`  in  8  byte from `PS2_Controller`.
- `received_data_en`  in  1  one-cycle strobe; `received_data` is valid in that cycle.
- `flush`  in  1  synchronous; clears both bitmaps and returns the FSM to IDLE.
- `p1_keys`  out  5  {attack, right, down, left, up} held state, player 1.
- `p2_keys`  out  5  same bit order, player 2.
- `p1_attack_pulse`, `p2_attack_pulse`  out  1 each  one cycle on a new attack press.
- `key_event`  out  1  one-cycle strobe per completed make or break code.
- `event_code`  out  8  final byte of the completed sequence.
- `event_release`  out  1  1 means break, 0 means make.
- `event_extended`  out  1  1 means the sequence was E0-prefixed.
- `seq_timeout`  out  1  one-cycle strobe when a partial sequence is abandoned.

## Operation
- Key map for player 1 (non-extended): up 1D (W), left 1C (A), down 1B (S), right 23 (D), attack 29 (Space).
- Key map for player 2 (extended E0): up 75, left 6B, down 72, right 74. Player 2 attack is 5A, with or without E0.
- All other codes are unmapped. They still produce `key_event`; bitmaps are unchanged.
- FSM states: IDLE, BRK, EXT, EXT_BRK, PAUSE.
- IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - E1 goes to PAUSE and loads the skip counter with 7.
  - AA, FA, FE, EE, 00, FF are ignored and the FSM stays in IDLE.
  - Any other byte completes a make code (ext=0).
- BRK: any byte other than E0, F0, E1 completes a break code (ext=0), then IDLE.
- EXT: F0 goes to EXT_BRK. Any byte other than E0, F0, E1 completes a make code (ext=1), then IDLE.
- EXT_BRK: any byte other than E0, F0, E1 completes a break code (ext=1), then IDLE.
- Prefix arriving out of place (E0, F0 or E1 in BRK, EXT or EXT_BRK): the pending sequence is discarded with no event and no `seq_timeout`. The prefix is then processed as if the FSM were in IDLE.
- PAUSE: each byte decrements the skip counter. The FSM returns to IDLE after the 7th byte. No events are produced and no prefixes are interpreted.
- Completed mapped make: the key's bit is set. Completed mapped break: the bit is cleared.
- Attack pulse fires only when the attack bit goes 0→1. A repeated make while the key is held gives `key_event` but no pulse.
- Timeout counter:
  - Cleared on every `received_data_en`.
  - Counts only while the FSM is not IDLE.
  - On reaching `TIMEOUT_CYCLES`-1, the FSM goes to IDLE and `seq_timeout` pulses.
  - Bitmaps are unchanged on timeout.
- `flush` has priority over a same-cycle `received_data_en`: the byte is dropped and no event is produced.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- Latency: bitmaps, `key_event`, `event_*` and attack pulses update on the first clock edge after the cycle in which the completing byte's `received_data_en` is high. All outputs are registered.
- `event_code`, `event_release`, `event_extended` hold their value until the next event. `key_event` is high for exactly one cycle.
- One byte is processed per strobe. Back-to-back strobes on consecutive cycles must be accepted.
- Timeout boundary:
  - Strobe in the same cycle the counter would expire: the byte is processed and the timeout does not fire.
  - Timeout is not counted in IDLE.
  - Timeout also applies in PAUSE.
- Reset asserted mid-sequence: immediate return to IDLE with all bitmaps cleared. The next byte is decoded from IDLE.

## Test plan
- Byte 1D, then F0 1D → `p1_keys`=00001 then 00000. Two `key_event` pulses: (1D, rel 0, ext 0) then (1D, rel 1, ext 0).
- Byte 29 three times (typematic) → `p1_attack_pulse` once, three `key_event`s, `p1_keys[4]`=1 throughout.
- E0 75, then E0 F0 75 → `p2_keys`=00001 then 00000. Events carry ext=1. `p1_keys` stays 0.
- E1 14 77 E1 F0 14 F0 77, then 23 → no events during the Pause sequence. Then one event with code 23, and `p1_keys`=01000.
- Bench with `TIMEOUT_CYCLES`=16: byte F0, then idle 16 cycles → `seq_timeout` pulses once. A following 1C gives a make event (rel 0) and `p1_keys[1]`=1.
- F0, then E0, then 74 → no event for the discarded F0. One event (74, rel 0, ext 1), `p2_keys[3]`=1. A `flush` then clears `p2_keys`. `reset` asserted mid-E0 returns all outputs to 0.
